// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single-port data memory (async read, write on posedge) between the
// CPU M-stage and a DMA/loader port. The registered grant FSM gives one word
// access per grant cycle. The CPU has fixed priority, and a starvation guard lets
// a losing DMA requester win eventually.
// Optional multi-beat DMA grants are enabled by defining DM_ARB_BURST_EN.
//
// state | meaning
// IDLE  | no grant; mem_* driven to 0
// CPU   | CPU port owns the memory this cycle (cpu_ack = cpu_req)
// DMA   | DMA port owns the memory this cycle (dma_ack = dma_req); with bursts, held for beats+1 cycles

module dm_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [3:0]        dma_len,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, CPU = 2'd1, DMA = 2'd2} grantState;

  // The starvation guard counts down from STARVE_LIMIT; reaching zero means DMA
  // has lost STARVE_LIMIT consecutive cycles.
  localparam int STW = $clog2(STARVE_LIMIT + 1);
  localparam logic [STW-1:0] STARVE_INIT = STW'(STARVE_LIMIT);

  grantState      state, stateNext;
  logic [STW-1:0] starveLeft, starveLeftNext;
  logic           cpuElig, dmaElig;

`ifdef DM_ARB_BURST_EN
  localparam logic [3:0] BEAT_MAX = 4'(MAX_BURST - 1);
  logic [3:0] beatsLeft, beatsLeftNext;
  logic [3:0] lenClamped;
  assign lenClamped = (dma_len > BEAT_MAX) ? BEAT_MAX : dma_len;
`else
  logic unusedCfg;
  assign unusedCfg = ^{dma_len, MAX_BURST > 1};
`endif

  // Grant register, starvation counter and burst beat counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starveLeft <= STARVE_INIT;
`ifdef DM_ARB_BURST_EN
      beatsLeft  <= 4'd0;
`endif
    end else begin
      state      <= stateNext;
      starveLeft <= starveLeftNext;
`ifdef DM_ARB_BURST_EN
      beatsLeft  <= beatsLeftNext;
`endif
    end
  end

  // Next grant: the port served this cycle is masked so it must re-arbitrate
  always_comb begin
    stateNext      = IDLE;
    starveLeftNext = starveLeft;
    cpuElig        = cpu_req && (state != CPU);
    dmaElig        = dma_req && (state != DMA);

    if (!dma_req || state == DMA) begin
      starveLeftNext = STARVE_INIT;
    end else if (starveLeft != '0) begin
      starveLeftNext = starveLeft - 1'b1;
    end

`ifdef DM_ARB_BURST_EN
    beatsLeftNext = beatsLeft;
    if (state == DMA && dma_req && beatsLeft != 4'd0) begin
      stateNext     = DMA;
      beatsLeftNext = beatsLeft - 4'd1;
    end else begin
      beatsLeftNext = 4'd0;
      if (cpuElig && dmaElig) begin
        stateNext = (starveLeft == '0) ? DMA : CPU;
      end else if (cpuElig) begin
        stateNext = CPU;
      end else if (dmaElig) begin
        stateNext = DMA;
      end
      if (stateNext == DMA) begin
        beatsLeftNext = lenClamped;
      end
    end
`else
    if (cpuElig && dmaElig) begin
      stateNext = (starveLeft == '0) ? DMA : CPU;
    end else if (cpuElig) begin
      stateNext = CPU;
    end else if (dmaElig) begin
      stateNext = DMA;
    end
`endif
  end

  // Memory-side mux and acks; everything is quiet while reset is held
  always_comb begin
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ack   = reset && cpu_req;
        mem_we    = reset && cpu_req && cpu_we;
      end
      DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_ack   = reset && dma_req;
        mem_we    = reset && dma_req && dma_we;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign dma_rdata = dma_ack ? mem_rdata : '0;
  assign cpu_stall = cpu_req && !cpu_ack;
  assign owner     = reset ? state : 2'd0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a directed vector table, then randomized traffic
// checked against a grant-level reference model. Defining DM_ARB_BURST_EN also
// enables the burst sequences and burst rules in the model.

module tb_dm_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [3:0]        dma_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;
  logic [1:0]        owner;

  dm_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_len(dma_len), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // Data memory: async read, write on posedge
  logic [31:0] dm [0:1023];
  assign mem_rdata = dm[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) dm[mem_addr[11:2]] <= mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the memory (0 none, 1 cpu, 2 dma), how many
  // cycles DMA has lost in a row, remaining extra burst beats, and memory image.
  int          mGrant, mStarve, mBeats;
  logic [31:0] refMem [0:1023];
  logic [1:0]  eOwner;
  logic        eCpuAck, eDmaAck, eMemWe, eStall;
  logic [31:0] eAddr, eWdata, eCpuRd, eDmaRd;

  task automatic calcExpect();
    eCpuAck = reset && mGrant == 1 && cpu_req;
    eDmaAck = reset && mGrant == 2 && dma_req;
    eOwner  = reset ? 2'(mGrant) : 2'd0;
    eMemWe  = (eCpuAck && cpu_we) || (eDmaAck && dma_we);
    eAddr   = (mGrant == 1) ? cpu_addr  : (mGrant == 2) ? dma_addr  : 32'd0;
    eWdata  = (mGrant == 1) ? cpu_wdata : (mGrant == 2) ? dma_wdata : 32'd0;
    eCpuRd  = eCpuAck ? refMem[cpu_addr[11:2]] : 32'd0;
    eDmaRd  = eDmaAck ? refMem[dma_addr[11:2]] : 32'd0;
    eStall  = cpu_req && !eCpuAck;
  endtask

  task automatic checkModel();
    calcExpect();
    chk("owner", owner, eOwner);
    chk("cpu_ack", cpu_ack, eCpuAck);
    chk("dma_ack", dma_ack, eDmaAck);
    chk("mem_we", mem_we, eMemWe);
    chk("cpu_stall", cpu_stall, eStall);
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_wdata", mem_wdata, eWdata);
    chk("cpu_rdata", cpu_rdata, eCpuRd);
    chk("dma_rdata", dma_rdata, eDmaRd);
  endtask

  function automatic int arbitrate(input bit cpuElig, input bit dmaElig, input int starve);
    if (cpuElig && dmaElig) return (starve >= STARVE_LIMIT) ? 2 : 1;
    if (cpuElig) return 1;
    if (dmaElig) return 2;
    return 0;
  endfunction

  // Called just after a posedge, with that cycle's inputs still applied
  task automatic modelAdvance();
    int nxt;
    calcExpect();
    if (!reset) begin
      mGrant = 0; mStarve = 0; mBeats = 0;
      return;
    end
    if (eMemWe) refMem[eAddr[11:2]] = eWdata;
`ifdef DM_ARB_BURST_EN
    if (mGrant == 2 && dma_req && mBeats > 0) begin
      nxt = 2;
      mBeats = mBeats - 1;
    end else begin
      nxt = arbitrate(cpu_req && mGrant != 1, dma_req && mGrant != 2, mStarve);
      mBeats = (nxt == 2) ? ((int'(dma_len) > MAX_BURST - 1) ? MAX_BURST - 1 : int'(dma_len)) : 0;
    end
`else
    nxt = arbitrate(cpu_req && mGrant != 1, dma_req && mGrant != 2, mStarve);
`endif
    if (dma_req && mGrant != 2) mStarve = (mStarve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mStarve + 1;
    else mStarve = 0;
    mGrant = nxt;
  endtask

  task automatic runCycle();
    #1;
    checkModel();
    @(posedge clk);
    modelAdvance();
  endtask

  typedef struct {
    logic        rst, cReq, cWe;
    logic [31:0] cAddr, cWd;
    logic        dReq, dWe;
    logic [31:0] dAddr, dWd;
    logic [1:0]  eOwner;
    logic        eCAck, eDAck, eWe, eStall;
    logic [31:0] eCRd, eDRd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic cReq, input logic cWe,
                              input logic [31:0] cAddr, input logic [31:0] cWd,
                              input logic dReq, input logic dWe,
                              input logic [31:0] dAddr, input logic [31:0] dWd,
                              input logic [1:0] eOw, input logic eCAck, input logic eDAck,
                              input logic eWe, input logic eStall,
                              input logic [31:0] eCRd, input logic [31:0] eDRd);
    vec_t v;
    v.rst = rst; v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cWd = cWd;
    v.dReq = dReq; v.dWe = dWe; v.dAddr = dAddr; v.dWd = dWd;
    v.eOwner = eOw; v.eCAck = eCAck; v.eDAck = eDAck; v.eWe = eWe; v.eStall = eStall;
    v.eCRd = eCRd; v.eDRd = eDRd;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm[i]     = 32'hA500_0000 | 32'(i);
      refMem[i] = 32'hA500_0000 | 32'(i);
    end
    mGrant = 0; mStarve = 0; mBeats = 0;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_len = 4'd0;

    // Reset held with both requesting, then release: CPU writes, DMA writes
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1,1,32'h10,32'h1234ABCD, 1,1,32'h40,32'hDEADBEEF, 0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(1, 1,1,32'h10,32'h1234ABCD, 1,1,32'h40,32'hDEADBEEF, 0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(1, 1,1,32'h10,32'h1234ABCD, 1,1,32'h40,32'hDEADBEEF, 1, 1,0,1,0, 32'hA5000004, 0));
    vecs.push_back(mk(1, 1,0,32'h10,0,            1,1,32'h40,32'hDEADBEEF, 2, 0,1,1,1, 0, 32'hA5000010));
    // CPU reads back both written words; one stall cycle before each ack
    vecs.push_back(mk(1, 1,0,32'h10,0, 0,0,0,0, 1, 1,0,0,0, 32'h1234ABCD, 0));
    vecs.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0, 0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(1, 1,0,32'h40,0, 0,0,0,0, 1, 1,0,0,0, 32'hDEADBEEF, 0));
    // DMA drops its request in the grant cycle: no ack, no write
    vecs.push_back(mk(1, 0,0,0,0, 1,1,32'h44,32'h55AA55AA, 0, 0,0,0,0, 0, 0));
    vecs.push_back(mk(1, 0,0,0,0, 0,1,32'h44,32'h55AA55AA, 2, 0,0,0,0, 0, 0));
    vecs.push_back(mk(1, 1,0,32'h44,0, 0,0,0,0, 0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(1, 1,0,32'h44,0, 0,0,0,0, 1, 1,0,0,0, 32'hA5000011, 0));
    // Continuous contention: grants alternate, neither side waits long
    vecs.push_back(mk(1, 1,0,32'h10,0, 1,0,32'h40,0, 0, 0,0,0,1, 0, 0));
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk(1, 1,0,32'h10,0, 1,0,32'h40,0, 1, 1,0,0,0, 32'h1234ABCD, 0));
      vecs.push_back(mk(1, 1,0,32'h10,0, 1,0,32'h40,0, 2, 0,1,0,1, 0, 32'hDEADBEEF));
    end
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0,0, 0, 0));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      cpu_req = vecs[i].cReq; cpu_we = vecs[i].cWe; cpu_addr = vecs[i].cAddr; cpu_wdata = vecs[i].cWd;
      dma_req = vecs[i].dReq; dma_we = vecs[i].dWe; dma_addr = vecs[i].dAddr; dma_wdata = vecs[i].dWd;
      dma_len = 4'd0;
      #1;
      chk($sformatf("v%0d_owner", i), owner, vecs[i].eOwner);
      chk($sformatf("v%0d_cpu_ack", i), cpu_ack, vecs[i].eCAck);
      chk($sformatf("v%0d_dma_ack", i), dma_ack, vecs[i].eDAck);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].eWe);
      chk($sformatf("v%0d_cpu_stall", i), cpu_stall, vecs[i].eStall);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].eCRd);
      chk($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].eDRd);
      @(posedge clk);
      modelAdvance();
    end

`ifdef DM_ARB_BURST_EN
    // Bursts with the CPU requesting throughout; measure the first DMA ack run
    for (int k = 0; k < 2; k++) begin
      int runLen = 0;
      bit done = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = !done; dma_we = 1'b1; dma_len = (k == 0) ? 4'd3 : 4'd15;
        dma_addr = 32'h20 + 32'(4 * runLen); dma_wdata = 32'hB000_0000 | 32'(runLen);
        runCycle();
        if (dma_ack) runLen++;
        else if (runLen > 0) done = 1;
      end
      chk($sformatf("burst%0d_len", k), runLen, (k == 0) ? 4 : MAX_BURST);
    end
    // Reset in the middle of a burst
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      reset = (c != 4);
      cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_len = 4'd7;
      dma_addr = 32'h80 + 32'(4 * c); dma_wdata = 32'hC000_0000 | 32'(c);
      runCycle();
    end
`endif

    // Randomized traffic against the model, with occasional reset pulses
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 63) != 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 32'($urandom_range(0, 15) * 4);
      cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 2) != 0);
      dma_we    = 1'($urandom_range(0, 1));
      dma_addr  = 32'($urandom_range(0, 15) * 4);
      dma_wdata = $urandom;
      dma_len   = 4'($urandom_range(0, 15));
      runCycle();
    end

    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    for (int i = 0; i < 64; i++) chk($sformatf("dm_word%0d", i), dm[i], refMem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
